// File: rtl/slot_pkg.sv
// Shared types and defaults for the slot input conditioning chain.
package slot_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        PEND_LOW    = 2'b10
    } dbnc_state_t;

    localparam int DEF_N_CH       = 3;
    localparam int DEF_SAMPLE_DIV = 50000;
    localparam int DEF_STABLE_CNT = 10;

endpackage

// File: rtl/slot_input_debounce_if.sv
// Raw inputs in, debounced levels and edge pulses out.
interface slot_input_debounce_if #(
    parameter int N_CH = 3
);

    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] clean;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            tick;

    modport master (
        output raw_in,
        input  clean,
        input  rise,
        input  fall,
        input  tick
    );

    modport slave (
        input  raw_in,
        output clean,
        output rise,
        output fall,
        output tick
    );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, tick-qualified FSM, registered level and pulses.
module debounce_channel
    import slot_pkg::*;
#(
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic          r_s1, r_s2;
    dbnc_state_t   r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic          r_clean, r_rise, r_fall;
    logic          w_rise_d, w_fall_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_clean <= (w_state_d == STABLE_HIGH) || (w_state_d == PEND_LOW);
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        if (i_tick) begin
            unique case (r_state)
                STABLE_LOW: begin
                    if (r_s2) begin
                        if (STABLE_CNT == 1) begin
                            w_state_d = STABLE_HIGH;
                            w_rise_d  = 1'b1;
                        end else begin
                            w_state_d = PEND_HIGH;
                            w_cnt_d   = CW'(1);
                        end
                    end
                end
                PEND_HIGH: begin
                    if (!r_s2) begin
                        w_state_d = STABLE_LOW;
                        w_cnt_d   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_d = STABLE_HIGH;
                        w_cnt_d   = '0;
                        w_rise_d  = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!r_s2) begin
                        if (STABLE_CNT == 1) begin
                            w_state_d = STABLE_LOW;
                            w_fall_d  = 1'b1;
                        end else begin
                            w_state_d = PEND_LOW;
                            w_cnt_d   = CW'(1);
                        end
                    end
                end
                PEND_LOW: begin
                    if (r_s2) begin
                        w_state_d = STABLE_HIGH;
                        w_cnt_d   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_d = STABLE_LOW;
                        w_cnt_d   = '0;
                        w_fall_d  = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_d = STABLE_LOW;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/slot_input_debounce.sv
// Top level: shared sample prescaler driving N_CH independent debounce channels.
module slot_input_debounce
    import slot_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT
) (
    input  logic CLK,
    input  logic RESET,
    slot_input_debounce_if.slave bus
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(SAMPLE_DIV - 1);

    if (SAMPLE_DIV < 1 || STABLE_CNT < 1) begin : g_bad_param
        $error("slot_input_debounce: SAMPLE_DIV and STABLE_CNT must both be >= 1");
    end

    logic [PW-1:0] r_div;
    logic          w_tick;

    // Masked during reset so no tick is seen while everything is being cleared.
    assign w_tick = (r_div == DIV_LAST) && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + PW'(1);
        end
    end

    assign bus.tick = w_tick;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT (STABLE_CNT)
        ) u_ch (
            .i_clk   (CLK),
            .i_rst   (RESET),
            .i_tick  (w_tick),
            .i_raw   (bus.raw_in[g]),
            .o_clean (bus.clean[g]),
            .o_rise  (bus.rise[g]),
            .o_fall  (bus.fall[g])
        );
    end

endmodule
